demux_1_2_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer. It is the steering counterpart of the 2-to-1 operand selector.
- Takes one valid/ready data stream plus a per-word select and routes each word to output channel A (select 0) or channel B (select 1).
- Each channel has a 2-entry buffer, so one slow consumer does not stall the other channel once its word is buffered.
- Used in the MDR datapath to return a result either to the writeback path or to the iteration feedback path.

---
 rtl/demux_1_2_stream.sv | 96 +++++++++
 tb/tb_demux_1_2_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux_1_2_stream.sv
// Registered 1-to-2 stream demultiplexer: each input word is steered by i_sel into
// a 2-entry FIFO for channel A or B, each channel with its own delivered-word counter.
module demux_1_2_stream #(
    parameter int DW = 4,
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_data,
    input  logic          i_sel,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [DW-1:0] o_a_data,
    output logic          o_a_valid,
    input  logic          i_a_ready,
    output logic [DW-1:0] o_b_data,
    output logic          o_b_valid,
    input  logic          i_b_ready,
    output logic [CW-1:0] o_a_cnt,
    output logic [CW-1:0] o_b_cnt
);

    logic [1:0]         full;
    logic [1:0]         ch_ready;
    logic [1:0]         ch_valid;
    logic [1:0][DW-1:0] ch_data;
    logic [1:0][CW-1:0] ch_cnt;

    // Readiness depends only on the registered occupancy, never on the consumers.
    assign o_ready  = i_sel ? !full[1] : !full[0];
    assign ch_ready = {i_b_ready, i_a_ready};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic [DW-1:0] head_q, head_d;
            logic [DW-1:0] tail_q, tail_d;
            logic [1:0]    count_q, count_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          push;
            logic          pop;

            assign push = i_valid && o_ready && (i_sel == 1'(gi));
            assign pop  = (count_q != 2'd0) && ch_ready[gi];

            always_comb begin
                head_d  = head_q;
                tail_d  = tail_q;
                count_d = count_q;
                cnt_d   = cnt_q + CW'(pop);
                if (push && pop) begin
                    // Only reachable at occupancy 1: the new word becomes the head.
                    head_d = i_data;
                end else if (push) begin
                    if (count_q == 2'd0) begin
                        head_d = i_data;
                    end else begin
                        tail_d = i_data;
                    end
                    count_d = count_q + 2'd1;
                end else if (pop) begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                    end
                    count_d = count_q - 2'd1;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    head_q  <= '0;
                    tail_q  <= '0;
                    count_q <= '0;
                    cnt_q   <= '0;
                end else begin
                    head_q  <= head_d;
                    tail_q  <= tail_d;
                    count_q <= count_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign full[gi]     = (count_q == 2'd2);
            assign ch_valid[gi] = (count_q != 2'd0);
            assign ch_data[gi]  = head_q;
            assign ch_cnt[gi]   = cnt_q;
        end
    endgenerate

    assign o_a_data  = ch_data[0];
    assign o_a_valid = ch_valid[0];
    assign o_a_cnt   = ch_cnt[0];
    assign o_b_data  = ch_data[1];
    assign o_b_valid = ch_valid[1];
    assign o_b_cnt   = ch_cnt[1];

endmodule

// File: tb/tb_demux_1_2_stream.sv
// Bench for demux_1_2_stream: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the two channels.
module tb_demux_1_2_stream;

    localparam int DW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data;
    logic          sel;
    logic          valid;
    logic          ready;
    logic [DW-1:0] a_data, b_data;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [CW-1:0] a_cnt, b_cnt;

    always #5 clk = ~clk;

    demux_1_2_stream #(.DW(DW), .CW(CW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_sel     (sel),
        .i_valid   (valid),
        .o_ready   (ready),
        .o_a_data  (a_data),
        .o_a_valid (a_valid),
        .i_a_ready (a_ready),
        .o_b_data  (b_data),
        .o_b_valid (b_valid),
        .i_b_ready (b_ready),
        .o_a_cnt   (a_cnt),
        .o_b_cnt   (b_cnt)
    );

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] last_a, last_b;
    int            ca, cb;
    bit            accepted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        ca = 0;
        cb = 0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model over the edge.
    task automatic cycle();
        bit rdy, push, pa, pb;
        logic [DW-1:0] w;
        @(negedge clk);
        rdy = sel ? (qb.size() < 2) : (qa.size() < 2);
        check("ready",   32'(ready),   32'(rdy));
        check("a_valid", 32'(a_valid), 32'(qa.size() != 0));
        check("b_valid", 32'(b_valid), 32'(qb.size() != 0));
        check("a_data",  32'(a_data),  32'(qa.size() != 0 ? qa[0] : last_a));
        check("b_data",  32'(b_data),  32'(qb.size() != 0 ? qb[0] : last_b));
        check("a_cnt",   32'(a_cnt),   32'(ca % (1 << CW)));
        check("b_cnt",   32'(b_cnt),   32'(cb % (1 << CW)));
        push = valid && rdy;
        pa   = (qa.size() != 0) && a_ready;
        pb   = (qb.size() != 0) && b_ready;
        @(posedge clk);
        accepted = push && !rst;
        if (rst) begin
            model_reset();
            $display("t=%0t reset", $time);
        end else begin
            if (pa) begin
                w = qa.pop_front();
                last_a = w;
                ca++;
                $display("t=%0t A delivers %0h", $time, w);
            end
            if (pb) begin
                w = qb.pop_front();
                last_b = w;
                cb++;
                $display("t=%0t B delivers %0h", $time, w);
            end
            if (push) begin
                if (sel) qb.push_back(data);
                else     qa.push_back(data);
                $display("t=%0t accept %0h -> %s", $time, data, sel ? "B" : "A");
            end
        end
        #1;
    endtask

    task automatic put(input logic s, input logic [DW-1:0] d);
        valid = 1'b1;
        sel   = s;
        data  = d;
        accepted = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) check("put_timeout", 32'd0, 32'd1);
        valid = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1; valid = 1'b0; sel = 1'b0; data = '0;
        a_ready = 1'b0; b_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Basic routing to both channels
        a_ready = 1'b1; b_ready = 1'b1;
        put(1'b0, 4'h3);
        put(1'b1, 4'hC);
        cycle(); cycle();

        // Fill A while its consumer stalls; B still accepts
        a_ready = 1'b0;
        put(1'b0, 4'h1);
        put(1'b0, 4'h2);
        valid = 1'b1; sel = 1'b0; data = 4'h4;
        cycle();
        valid = 1'b0;
        put(1'b1, 4'h9);
        a_ready = 1'b1;
        cycle(); cycle(); cycle();

        // Push and pop on A in the same cycle at occupancy 1
        a_ready = 1'b0;
        put(1'b0, 4'h5);
        a_ready = 1'b1;
        put(1'b0, 4'h6);
        cycle(); cycle();

        // Reset discards buffered words
        a_ready = 1'b0;
        put(1'b0, 4'h7);
        put(1'b0, 4'h8);
        a_ready = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle(); cycle();

        // Counter wrap on B
        b_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            put(1'b1, DW'(i + 1));
            cycle();
        end
        cycle();

        // Random traffic with source holding words until accepted
        valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!valid || accepted) begin
                valid = 1'($urandom_range(0, 1));
                sel   = 1'($urandom_range(0, 1));
                data  = DW'($urandom);
            end
            a_ready = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            cycle();
            if (rst) valid = 1'b0;
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
